// File: rtl/seg7_pkg.sv
// Shared glyph constants and BCD-to-segment decode for the 7-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the driver outputs.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD codes 10..15 render as a dash so a bad digit is visible rather than garbage.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit decoder: BCD digit plus blank request to an active-high glyph.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = blank ? SEG_BLANK : digit_to_seg(digit);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with shadowed digits, anode ghost blanking,
// leading-zero suppression, fixed decimal point and a once-per-scan frame pulse.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 64,
    parameter int unsigned DP_POS      = 2,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned AN_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_lzb,
    input  logic [3:0] i_Digit1,
    input  logic [3:0] i_Digit2,
    input  logic [3:0] i_Digit3,
    input  logic [3:0] i_Digit4,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_an,
    output logic       o_frame
);

    localparam int unsigned      CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic             SEG_INV   = (SEG_ACT_LOW != 0);
    localparam logic             AN_INV    = (AN_ACT_LOW != 0);
    localparam logic             DP_USED   = (DP_POS < 4);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic             live_q, live_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_q, frame_d;

    logic             wrap;
    logic             in_blank;
    logic             zero_above;
    logic             lz_blank;
    logic [3:0]       cur_digit;
    logic [6:0]       glyph;

    seg7_decoder u_decoder (
        .digit (cur_digit),
        .blank (lz_blank),
        .glyph (glyph)
    );

    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        // Glyphs stay dark until the first slot advance after reset.
        live_d   = live_q | wrap;
        frame_d  = wrap && (idx_q == 2'd3);
        digit_d  = i_load ? {i_Digit4, i_Digit3, i_Digit2, i_Digit1} : digit_q;
        in_blank = (cnt_q < CNT_BLANK);

        cur_digit  = digit_q[idx_q];
        zero_above = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ((k >= int'(idx_q)) && (digit_q[k] != 4'd0)) begin
                zero_above = 1'b0;
            end
        end
        // Digits at or right of the decimal point are never suppressed.
        lz_blank = i_lzb && (idx_q != 2'd0) && zero_above
                   && !(DP_USED && (32'(idx_q) <= DP_POS));

        seg_d = live_q ? glyph : SEG_BLANK;
        an_d  = (live_q && !in_blank) ? (4'b0001 << idx_q) : 4'b0000;
        dp_d  = live_q && !in_blank && DP_USED && (32'(idx_q) == DP_POS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            digit_q <= '0;
            live_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            an_q    <= 4'b0000;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            live_q  <= live_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg   = seg_q ^ {7{SEG_INV}};
    assign o_dp    = dp_q ^ SEG_INV;
    assign o_an    = an_q ^ {4{AN_INV}};
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed table, multi-cycle corner sequences
// and randomized traffic against an elapsed-cycle reference model, across three configurations.
module tb_seg7_scan_driver;

    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } out_t;

    typedef struct {
        logic [15:0] digits;
        logic        lzb;
        int          idx;
        logic [6:0]  seg_a;
        logic        dp_a;
        logic [6:0]  seg_b;
        logic [6:0]  seg_c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_load = 1'b0;
    logic       i_lzb = 1'b0;
    logic [3:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b, an_c;
    logic       fr_a, fr_b, fr_c;

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DP_POS(2), .SEG_ACT_LOW(1), .AN_ACT_LOW(1))
    dut_a (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_lzb(i_lzb),
        .i_Digit1(d1), .i_Digit2(d2), .i_Digit3(d3), .i_Digit4(d4),
        .o_seg(seg_a), .o_dp(dp_a), .o_an(an_a), .o_frame(fr_a)
    );

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DP_POS(4), .SEG_ACT_LOW(1), .AN_ACT_LOW(1))
    dut_b (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_lzb(i_lzb),
        .i_Digit1(d1), .i_Digit2(d2), .i_Digit3(d3), .i_Digit4(d4),
        .o_seg(seg_b), .o_dp(dp_b), .o_an(an_b), .o_frame(fr_b)
    );

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DP_POS(2), .SEG_ACT_LOW(0), .AN_ACT_LOW(0))
    dut_c (
        .clk(clk), .rst_n(rst_n), .i_load(i_load), .i_lzb(i_lzb),
        .i_Digit1(d1), .i_Digit2(d2), .i_Digit3(d3), .i_Digit4(d4),
        .o_seg(seg_c), .o_dp(dp_c), .o_an(an_c), .o_frame(fr_c)
    );

    // Reference: n = clock edges since reset release; slot and phase follow by division.
    function automatic out_t model(int n, int dp_pos, logic [15:0] sh, logic lzb);
        out_t o;
        int   pres, idx, above;
        bit   blank;
        pres    = n % SD;
        idx     = (n / SD) % 4;
        o       = '0;
        o.frame = (pres == SD - 1) && (idx == 3);
        if (n >= SD) begin
            above = 0;
            for (int k = idx; k < 4; k++) above += int'(sh[k*4 +: 4]);
            blank = lzb && (idx != 0) && !((dp_pos < 4) && (idx <= dp_pos)) && (above == 0);
            o.seg = blank ? 7'h00 : GLYPH[sh[idx*4 +: 4]];
            if (pres >= BC) begin
                o.an = 4'b0001 << idx;
                o.dp = (idx == dp_pos);
            end
        end
        return o;
    endfunction

    int          n;
    logic [15:0] sh;
    out_t        exp_a, exp_b, exp_c;

    always @(posedge clk) begin
        if (!rst_n) begin
            n     <= 0;
            sh    <= '0;
            exp_a <= '0;
            exp_b <= '0;
            exp_c <= '0;
        end else begin
            exp_a <= model(n, 2, sh, i_lzb);
            exp_b <= model(n, 4, sh, i_lzb);
            exp_c <= model(n, 2, sh, i_lzb);
            n     <= n + 1;
            if (i_load) sh <= {d4, d3, d2, d1};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance one clock; compare every DUT against the model at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (mdl_on) begin
            check("model_a", {fr_a, an_a, dp_a, seg_a},
                  {exp_a.frame, ~exp_a.an, ~exp_a.dp, ~exp_a.seg});
            check("model_b", {fr_b, an_b, dp_b, seg_b},
                  {exp_b.frame, ~exp_b.an, ~exp_b.dp, ~exp_b.seg});
            check("model_c", {fr_c, an_c, dp_c, seg_c},
                  {exp_c.frame, exp_c.an, exp_c.dp, exp_c.seg});
        end
    endtask

    // Tick at least once, until the model says slot k is lit.
    task automatic wait_slot(input int k);
        logic [3:0] oh;
        int         budget;
        oh     = 4'b0001 << k;
        budget = 0;
        do begin
            tick();
            budget++;
        end while ((exp_a.an != oh) && (budget < 40));
        check("wait_slot_timeout", 32'(exp_a.an == oh), 32'd1);
    endtask

    vec_t vecs [12];

    initial begin
        logic [3:0] oh, ohn;
        int         first, blanked;

        vecs[0]  = '{16'h4321, 1'b0, 0, 7'h79, 1'b1, 7'h79, 7'h06};
        vecs[1]  = '{16'h4321, 1'b0, 1, 7'h24, 1'b1, 7'h24, 7'h5B};
        vecs[2]  = '{16'h4321, 1'b0, 2, 7'h30, 1'b0, 7'h30, 7'h4F};
        vecs[3]  = '{16'h4321, 1'b0, 3, 7'h19, 1'b1, 7'h19, 7'h66};
        vecs[4]  = '{16'h0007, 1'b1, 3, 7'h7F, 1'b1, 7'h7F, 7'h00};
        vecs[5]  = '{16'h0007, 1'b1, 2, 7'h40, 1'b0, 7'h7F, 7'h3F};
        vecs[6]  = '{16'h0007, 1'b1, 1, 7'h40, 1'b1, 7'h7F, 7'h3F};
        vecs[7]  = '{16'h0007, 1'b1, 0, 7'h78, 1'b1, 7'h78, 7'h07};
        vecs[8]  = '{16'hC000, 1'b0, 3, 7'h3F, 1'b1, 7'h3F, 7'h40};
        vecs[9]  = '{16'hC000, 1'b1, 3, 7'h3F, 1'b1, 7'h3F, 7'h40};
        vecs[10] = '{16'h0000, 1'b1, 0, 7'h40, 1'b1, 7'h40, 7'h3F};
        vecs[11] = '{16'h0000, 1'b1, 1, 7'h40, 1'b1, 7'h7F, 7'h3F};

        // Reset held for 3 clocks, then first frame timing.
        rst_n = 1'b0;
        repeat (3) tick();
        mdl_on = 1'b1;
        check("rst_an", an_a, 32'hF);
        check("rst_seg", seg_a, 32'h7F);
        check("rst_frame", fr_a, 32'h0);
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c <= 8) begin
                check("pre_slot_an", an_a, 32'hF);
                check("pre_slot_seg", seg_a, 32'h7F);
            end
            if (fr_a && first == 0) first = c;
        end
        check("first_frame_cycle", first, 32);

        // Ghost blanking: 2 of every 8 cycles have no anode lit over a full scan.
        blanked = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            if (an_a == 4'hF) blanked++;
        end
        check("blank_cycles_per_scan", blanked, 8);

        // Table-driven glyph, dp and anode checks.
        foreach (vecs[i]) begin
            {d4, d3, d2, d1} = vecs[i].digits;
            i_lzb  = vecs[i].lzb;
            i_load = 1'b1;
            tick();
            i_load = 1'b0;
            wait_slot(vecs[i].idx);
            oh  = 4'b0001 << vecs[i].idx;
            ohn = ~oh;
            check($sformatf("vec%0d_seg_a", i), seg_a, vecs[i].seg_a);
            check($sformatf("vec%0d_dp_a", i), dp_a, vecs[i].dp_a);
            check($sformatf("vec%0d_seg_b", i), seg_b, vecs[i].seg_b);
            check($sformatf("vec%0d_seg_c", i), seg_c, vecs[i].seg_c);
            check($sformatf("vec%0d_an_a", i), an_a, ohn);
            check($sformatf("vec%0d_an_c", i), an_c, oh);
        end

        // Load held high while inputs ramp; last captured value must then hold.
        i_lzb  = 1'b0;
        i_load = 1'b1;
        for (int v = 0; v < 6; v++) begin
            {d4, d3, d2, d1} = {4'(v + 3), 4'(v + 2), 4'(v + 1), 4'(v)};
            tick();
        end
        i_load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            {d4, d3, d2, d1} = 16'($urandom);
            tick();
        end
        wait_slot(1);
        check("hold_idx1_seg", seg_a, 32'h02);
        wait_slot(3);
        check("hold_idx3_seg", seg_a, 32'h00);

        // Mid-slot reset at idx2 with a load pending.
        wait_slot(2);
        tick();
        rst_n  = 1'b0;
        i_load = 1'b1;
        {d4, d3, d2, d1} = 16'h9876;
        tick();
        rst_n  = 1'b0;
        i_load = 1'b0;
        check("midrst_an", an_a, 32'hF);
        check("midrst_seg", seg_a, 32'h7F);
        check("midrst_dp", dp_a, 32'h1);
        check("midrst_frame", fr_a, 32'h0);
        rst_n = 1'b1;
        wait_slot(3);
        check("midrst_shadow_idx3", seg_a, 32'h40);
        wait_slot(0);
        check("midrst_shadow_idx0", seg_a, 32'h40);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            i_load = ($urandom_range(0, 9) == 0);
            d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) i_lzb = ~i_lzb;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n  = 1'b1;
        i_load = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
